// File: rtl/fifo_pkg.sv
// Shared types, depth derivation and parameter legality helpers for the
// single-clock FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;
    localparam int DEFAULT_ADDRWIDTH = 5;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

    function automatic bit ae_level_ok(input int ae_level, input int depth);
        return (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Data and status bundle between a FIFO and its producer/consumer.
// The master side drives requests; the slave side (the FIFO) drives status.
interface sync_fifo_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5
);

    logic                 I_clr;
    logic [DATAWIDTH-1:0] I_data_in;
    logic                 I_wren;
    logic                 I_rden;
    logic [DATAWIDTH-1:0] O_data_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDRWIDTH:0]   O_count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output I_clr,
        output I_data_in,
        output I_wren,
        output I_rden,
        input  O_data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  O_count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  I_clr,
        input  I_data_in,
        input  I_wren,
        input  I_rden,
        output O_data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output O_count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one read port that is either
// registered (reset to zero, holds between reads) or purely combinational.
module fifo_dpram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5,
    parameter bit REG_READ  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [0:DEPTH-1];

    // Storage is deliberately left unreset so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    if (REG_READ) begin : g_reg_read
        logic [DATAWIDTH-1:0] rd_data_q;
        logic [DATAWIDTH-1:0] rd_data_d;

        always_comb begin
            rd_data_d = rd_data_q;
            if (rd_en) begin
                rd_data_d = mem[rd_addr];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end else begin : g_comb_read
        logic unused_comb_read;

        assign unused_comb_read = ^{rd_en, rst_n};
        assign rd_data          = mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, optional first-word-fall-through, flush and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH,
    parameter int AF_LEVEL  = fifo_depth(ADDRWIDTH) - 2,
    parameter int AE_LEVEL  = 2,
    parameter int FWFT      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);

    localparam int DEPTH = fifo_depth(ADDRWIDTH);

    localparam logic [ADDRWIDTH:0] DEPTH_CNT = DEPTH[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] AF_CNT    = AF_LEVEL[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] AE_CNT    = AE_LEVEL[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] PTR_ONE   = {{ADDRWIDTH{1'b0}}, 1'b1};

    if ((ADDRWIDTH < 1) || (clog2(DEPTH) != ADDRWIDTH)) begin : g_bad_addrwidth
        $error("sync_fifo: ADDRWIDTH must be at least 1");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af_level
        $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH");
    end
    if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae_level
        $error("sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [ADDRWIDTH:0]   wr_ptr_q;
    logic [ADDRWIDTH:0]   wr_ptr_d;
    logic [ADDRWIDTH:0]   rd_ptr_q;
    logic [ADDRWIDTH:0]   rd_ptr_d;
    logic [ADDRWIDTH:0]   count_q;
    logic [ADDRWIDTH:0]   count_d;
    fifo_flags_t          flags_q;
    fifo_flags_t          flags_d;
    logic                 overflow_q;
    logic                 overflow_d;
    logic                 underflow_q;
    logic                 underflow_d;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 ram_wr_en;
    logic                 ram_rd_en;
    logic [DATAWIDTH-1:0] ram_rd_data;

    // Acceptance looks only at the registered flags from the start of the cycle.
    assign wr_acc    = bus.I_wren & ~flags_q.full;
    assign rd_acc    = bus.I_rden & ~flags_q.empty;
    assign ram_wr_en = wr_acc & ~bus.I_clr;
    assign ram_rd_en = rd_acc & ~bus.I_clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.I_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.I_wren & flags_q.full);
            underflow_d = underflow_q | (bus.I_rden & flags_q.empty);
        end
    end

    // Every status flag is a registered function of the next occupancy.
    always_comb begin
        flags_d              = FLAGS_RESET;
        flags_d.full         = (count_d == DEPTH_CNT);
        flags_d.empty        = (count_d == '0);
        flags_d.almost_full  = (count_d >= AF_CNT);
        flags_d.almost_empty = (count_d <= AE_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flags_q     <= FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_dpram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .REG_READ  (FWFT == 0)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q[ADDRWIDTH-1:0]),
        .wr_data (bus.I_data_in),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q[ADDRWIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    assign bus.O_data_out   = ram_rd_data;
    assign bus.O_count      = count_q;
    assign bus.full         = flags_q.full;
    assign bus.empty        = flags_q.empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-read and an FWFT instance share one stimulus
// stream and are checked every cycle against a queue-based model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AF    = 30;
    localparam int AE    = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr   = 1'b0;
    logic          wren  = 1'b0;
    logic          rden  = 1'b0;
    logic [DW-1:0] din   = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q[$];
    logic          m_ovf     = 1'b0;
    logic          m_udf     = 1'b0;
    logic [DW-1:0] m_std_out = '0;
    bit            m_wr;
    bit            m_rd;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_std ();
    sync_fifo_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_fwft ();

    assign bus_std.I_clr      = clr;
    assign bus_std.I_wren     = wren;
    assign bus_std.I_rden     = rden;
    assign bus_std.I_data_in  = din;
    assign bus_fwft.I_clr     = clr;
    assign bus_fwft.I_wren    = wren;
    assign bus_fwft.I_rden    = rden;
    assign bus_fwft.I_data_in = din;

    sync_fifo #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE),
        .FWFT      (0)
    ) dut_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_std)
    );

    sync_fifo #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE),
        .FWFT      (1)
    ) dut_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fwft)
    );

    // Reference behaviour: a queue of stored words plus sticky error bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            m_std_out = '0;
        end else if (clr) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_wr = wren && (model_q.size() < DEPTH);
            m_rd = rden && (model_q.size() > 0);
            if (wren && (model_q.size() == DEPTH)) m_ovf = 1'b1;
            if (rden && (model_q.size() == 0))     m_udf = 1'b1;
            if (m_rd) m_std_out = model_q.pop_front();
            if (m_wr) model_q.push_back(din);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compareAll(input string tag, input logic [AW:0] cnt, input logic f,
                              input logic e, input logic af, input logic ae,
                              input logic ov, input logic un);
        int sz;
        sz = model_q.size();
        check({tag, ".count"},        32'(cnt), 32'(sz));
        check({tag, ".full"},         32'(f),   32'(sz == DEPTH));
        check({tag, ".empty"},        32'(e),   32'(sz == 0));
        check({tag, ".almost_full"},  32'(af),  32'(sz >= AF));
        check({tag, ".almost_empty"}, 32'(ae),  32'(sz <= AE));
        check({tag, ".overflow"},     32'(ov),  32'(m_ovf));
        check({tag, ".underflow"},    32'(un),  32'(m_udf));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            compareAll("std", bus_std.O_count, bus_std.full, bus_std.empty,
                       bus_std.almost_full, bus_std.almost_empty,
                       bus_std.overflow, bus_std.underflow);
            compareAll("fwft", bus_fwft.O_count, bus_fwft.full, bus_fwft.empty,
                       bus_fwft.almost_full, bus_fwft.almost_empty,
                       bus_fwft.overflow, bus_fwft.underflow);
            check("std.data_out", 32'(bus_std.O_data_out), 32'(m_std_out));
            if (model_q.size() > 0) begin
                check("fwft.data_out", 32'(bus_fwft.O_data_out), 32'(model_q[0]));
            end
        end
    end

    task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        clr  = c;
        wren = w;
        rden = r;
        din  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check({"lit.", name}, act, exp);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".std_count"},   32'(bus_std.O_count),      32'd0);
        checkOutput({tag, ".std_empty"},   32'(bus_std.empty),        32'd1);
        checkOutput({tag, ".std_ae"},      32'(bus_std.almost_empty), 32'd1);
        checkOutput({tag, ".std_full"},    32'(bus_std.full),         32'd0);
        checkOutput({tag, ".std_af"},      32'(bus_std.almost_full),  32'd0);
        checkOutput({tag, ".std_ovf"},     32'(bus_std.overflow),     32'd0);
        checkOutput({tag, ".std_udf"},     32'(bus_std.underflow),    32'd0);
        checkOutput({tag, ".std_dout"},    32'(bus_std.O_data_out),   32'h00);
        checkOutput({tag, ".fwft_count"},  32'(bus_fwft.O_count),     32'd0);
        checkOutput({tag, ".fwft_empty"},  32'(bus_fwft.empty),       32'd1);
    endtask

    initial begin
        $display("[TB] starting sync_fifo bench");
        repeat (2) @(posedge clk);
        #2;
        checkResetState("reset");
        rst_n = 1'b1;

        // Fill to full with 0x00..0x1F.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, DW'(i));
            if (i == 0) begin
                checkOutput("first_wr_empty", 32'(bus_std.empty), 32'd0);
                checkOutput("first_wr_count", 32'(bus_std.O_count), 32'd1);
                checkOutput("first_wr_fwft",  32'(bus_fwft.O_data_out), 32'h00);
            end
            if (i == 1) checkOutput("ae_at_2", 32'(bus_std.almost_empty), 32'd1);
            if (i == 2) checkOutput("ae_at_3", 32'(bus_std.almost_empty), 32'd0);
            if (i == 28) checkOutput("af_at_29", 32'(bus_std.almost_full), 32'd0);
            if (i == 29) checkOutput("af_at_30", 32'(bus_std.almost_full), 32'd1);
            if (i == 30) checkOutput("full_at_31", 32'(bus_std.full), 32'd0);
        end
        checkOutput("full_at_32",  32'(bus_std.full), 32'd1);
        checkOutput("count_at_32", 32'(bus_std.O_count), 32'd32);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE);
        checkOutput("ovf_set",     32'(bus_std.overflow), 32'd1);
        checkOutput("count_ovf",   32'(bus_std.O_count), 32'd32);

        // Drain; the dropped 0xEE must not appear at address 0.
        for (int j = 0; j < DEPTH; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            if (j == 0) checkOutput("drain_first", 32'(bus_std.O_data_out), 32'h00);
            if (j == 1) checkOutput("drain_second", 32'(bus_std.O_data_out), 32'h01);
        end
        checkOutput("drain_last",  32'(bus_std.O_data_out), 32'h1F);
        checkOutput("drain_empty", 32'(bus_std.empty), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("udf_set",     32'(bus_std.underflow), 32'd1);
        checkOutput("udf_hold",    32'(bus_std.O_data_out), 32'h1F);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("clr_ovf",     32'(bus_std.overflow), 32'd0);
        checkOutput("clr_udf",     32'(bus_std.underflow), 32'd0);
        checkOutput("clr_dout",    32'(bus_std.O_data_out), 32'h1F);

        // FWFT: the head word appears on the same edge empty drops.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
        checkOutput("fwft_a5",     32'(bus_fwft.O_data_out), 32'hA5);
        checkOutput("fwft_nempty", 32'(bus_fwft.empty), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("fwft_empty",  32'(bus_fwft.empty), 32'd1);
        checkOutput("std_a5",      32'(bus_std.O_data_out), 32'hA5);

        // Streaming at a constant level of 5 across several pointer wraps.
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0, DW'(8'h10 + k));
        for (int n = 0; n < 100; n++) applyStimulus(1'b0, 1'b1, 1'b1, DW'(8'h60 + n));
        checkOutput("stream_count", 32'(bus_std.O_count), 32'd5);
        checkOutput("stream_last",  32'(bus_std.O_data_out), 32'hBE);

        // Empty with both requests: write wins, read flagged.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
        checkOutput("emp_both_count", 32'(bus_std.O_count), 32'd1);
        checkOutput("emp_both_udf",   32'(bus_std.underflow), 32'd1);
        checkOutput("emp_both_fwft",  32'(bus_fwft.O_data_out), 32'h5A);

        // Full with both requests: read wins, write flagged.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, DW'(8'h40 + i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
        checkOutput("full_both_count", 32'(bus_std.O_count), 32'd31);
        checkOutput("full_both_ovf",   32'(bus_std.overflow), 32'd1);
        checkOutput("full_both_dout",  32'(bus_std.O_data_out), 32'h40);

        // Flush beats a concurrent write.
        for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("pre_clr_count", 32'(bus_std.O_count), 32'd12);
        checkOutput("pre_clr_dout",  32'(bus_std.O_data_out), 32'h53);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
        checkOutput("clr_wr_count", 32'(bus_std.O_count), 32'd0);
        checkOutput("clr_wr_empty", 32'(bus_std.empty), 32'd1);
        checkOutput("clr_wr_ovf",   32'(bus_std.overflow), 32'd0);
        checkOutput("clr_wr_dout",  32'(bus_std.O_data_out), 32'h53);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("clr_no_write", 32'(bus_std.O_count), 32'd0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, DW'(8'h31 + i));
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("pre_rst_dout", 32'(bus_std.O_data_out), 32'h31);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h34);
        #1;
        rst_n = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        #1;
        checkResetState("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, optional first-word-fall-through (FWFT) output, synchronous flush and sticky error flags. It is the single-clock-domain successor to the team's dual-clock FIFO. It is used wherever producer and consumer share one clock and need level-based flow control rather than only full/empty.

## Interface
Parameters:
- DATAWIDTH, 8: data word width in bits.
- ADDRWIDTH, 5: address width; depth DEPTH = 2^ADDRWIDTH.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = head word presented without a read request.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- I_clr  in  1  synchronous flush; discards contents.
- I_data_in  in  DATAWIDTH  write data.
- I_wren  in  1  write request.
- I_rden  in  1  read request (FWFT: pop/acknowledge head).
- O_data_out  out  DATAWIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- O_count  out  ADDRWIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Reset (rst_n low, asynchronous): pointers = 0, O_count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0, O_data_out = 0. RAM contents are not reset.
- Write accepted iff I_wren & !full. Read accepted iff I_rden & !empty. full and empty are the registered flags at the start of the cycle.
- A write while full is dropped and sets overflow. A read while empty is dropped and sets underflow. Both flags stay set until I_clr or reset.
- Simultaneous accepted write and read: O_count unchanged. The read returns the older head word, never the word being written.
- Full with wren and rden both high: the read is accepted and the write is rejected, which sets overflow. Empty with both high: the write is accepted and the read is rejected, which sets underflow.
- Binary pointers are ADDRWIDTH+1 bits. The RAM address is the low ADDRWIDTH bits. Wrap from DEPTH-1 to 0 is natural modulo.
- count_next = O_count + wr_acc − rd_acc. All flags are registered from count_next.
- I_clr takes priority over wren and rden in the same cycle. It zeroes the pointers and count, clears overflow and underflow, sets empty and almost_empty, and clears full and almost_full. O_data_out holds its value in standard mode.
- FWFT=0: O_data_out loads RAM[rd_addr] only on an accepted read, and holds otherwise.
- FWFT=1: O_data_out = RAM[rd_addr] combinationally whenever !empty. Its value is don't-care while empty. An accepted read advances to the next word.

## Timing
- Write accepted at edge k: empty falls and O_count increments after edge k.
- Standard mode: read accepted at edge k → data on O_data_out after edge k (1-cycle latency). Minimum write-to-data is 2 edges.
- FWFT mode: word written at edge k is on O_data_out after edge k, in the same cycle that empty deasserts.
- full asserts after the edge that accepts the DEPTH-th word. The next write is rejected.
- Back-to-back reads and writes run at 1 word per cycle indefinitely.

## Structure
- Package fifo_pkg: clog2 function, DEPTH derivation, and parameter legality checks for AF_LEVEL and AE_LEVEL.
- Sub-module fifo_dpram: one write port and one read port. The read port is registered or combinational, selected by parameter.
- Control logic (pointers, count, flags, error bits) lives in sync_fifo.

## Test plan
- Reset, then 32 writes of 0x00..0x1F with DEPTH=32 → full after the 32nd, almost_full from count 30, O_count=32. A 33rd write sets overflow and RAM is unchanged.
- Drain 32 reads, FWFT=0 → O_data_out sequence 0x00..0x1F each 1 cycle after its read, empty after the last. An extra read sets underflow.
- FWFT=1: single write of 0xA5 into an empty FIFO → O_data_out=0xA5 and empty=0 after the same edge. A read returns to empty=1.
- Continuous simultaneous wr/rd at count 5 for 100 cycles with wrap → O_count stays 5 and data is in order, no loss.
- Full with wren and rden both high → read accepted, write dropped, overflow=1, O_count=31.
- I_clr with O_count=12, overflow=1 and wren high → O_count=0, empty=1, overflow=0, no write. Async rst_n pulse mid-stream → all outputs at reset values immediately.
